// File: rtl/mips_pkg.sv
// Shared MIPS definitions for the instruction encoder/loader and its benches.
// Contents: opcode and funct constants, the 2-bit instruction kind, the loader
// FSM state type and a helper that says whether an R-type funct is supported.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

  typedef enum logic [1:0] {
    KindR   = 2'd0,
    KindLw  = 2'd1,
    KindSw  = 2'd2,
    KindBeq = 2'd3
  } instr_kind_e;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StLoad = 2'd1,
    StDone = 2'd2
  } load_state_e;

  // R-type functs the single-cycle datapath actually implements.
  function automatic logic funct_legal(input logic [5:0] funct);
    return funct inside {FUNCT_ADD, FUNCT_SUB, FUNCT_AND, FUNCT_OR, FUNCT_SLT};
  endfunction

endpackage

// File: rtl/instr_pack.sv
// Combinational field-to-word packer for the four MIPS kinds the processor decodes.
// Ports:
//   kind_i  - instruction kind (R, LW, SW, BEQ)
//   rs_i, rt_i, rd_i - register fields (rd_i only used by R-type)
//   funct_i - R-type function code (ignored for I-types)
//   imm_i   - immediate / branch offset (ignored for R-type)
//   word_o  - packed 32-bit machine word
module instr_pack
  import mips_pkg::*;
(
  input  instr_kind_e kind_i,
  input  logic [4:0]  rs_i,
  input  logic [4:0]  rt_i,
  input  logic [4:0]  rd_i,
  input  logic [5:0]  funct_i,
  input  logic [15:0] imm_i,
  output logic [31:0] word_o
);

  always_comb begin
    word_o = '0;
    unique case (kind_i)
      KindR:   word_o = {OP_RTYPE, rs_i, rt_i, rd_i, 5'b00000, funct_i};
      KindLw:  word_o = {OP_LW, rs_i, rt_i, imm_i};
      KindSw:  word_o = {OP_SW, rs_i, rt_i, imm_i};
      KindBeq: word_o = {OP_BEQ, rs_i, rt_i, imm_i};
      default: word_o = '0;
    endcase
  end

endmodule

// File: rtl/instr_encoder_loader.sv
// Streams field-level instruction descriptions into MIPS machine words and writes
// them to consecutive instruction memory words starting at address 0.
// Optional feature macro: ENC_CHECK_EN - reject R-type words whose funct is not
// one of add/sub/and/or/slt (consumed, not written, err pulses).
// Ports:
//   clk, rst_n        - clock, asynchronous active-low reset
//   start, finish     - session start / early end pulses
//   in_valid/in_ready - field handshake; in_kind/in_rs/in_rt/in_rd/in_funct/in_imm fields
//   imem_we/imem_addr/imem_wdata - registered instruction memory write port
//   count             - words written this session
//   done              - session finished
//   err               - one-cycle pulse per rejected word (0 without ENC_CHECK_EN)
module instr_encoder_loader
  import mips_pkg::*;
#(
  parameter int unsigned AW = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          finish,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [1:0]    in_kind,
  input  logic [4:0]    in_rs,
  input  logic [4:0]    in_rt,
  input  logic [4:0]    in_rd,
  input  logic [5:0]    in_funct,
  input  logic [15:0]   in_imm,
  output logic          imem_we,
  output logic [AW-1:0] imem_addr,
  output logic [31:0]   imem_wdata,
  output logic [AW:0]   count,
  output logic          done,
  output logic          err
);

  localparam logic [AW-1:0] LastAddr = '1;

  load_state_e   state_q;
  logic          we_q;
  logic [AW-1:0] addr_q;
  logic [31:0]   wdata_q;
  logic [AW:0]   count_q;
  logic          done_q;
  // finish arrived together with an acceptance: end once that word is written
  logic          fin_pend_q;

  logic          accept;
  logic          last_write;
  logic          word_ok;
  logic [31:0]   word;

  instr_pack u_pack (
    .kind_i  (instr_kind_e'(in_kind)),
    .rs_i    (in_rs),
    .rt_i    (in_rt),
    .rd_i    (in_rd),
    .funct_i (in_funct),
    .imm_i   (in_imm),
    .word_o  (word)
  );

`ifdef ENC_CHECK_EN
  logic err_q;

  always_comb begin
    word_ok = (instr_kind_e'(in_kind) != KindR) || funct_legal(in_funct);
  end

  assign err = err_q;
`else
  always_comb begin
    word_ok = 1'b1;
  end

  assign err = 1'b0;
`endif

  // The write to the top word fills memory, so no further word may be taken.
  always_comb begin
    last_write = we_q && (addr_q == LastAddr);
    in_ready   = (state_q == StLoad) && !last_write && !fin_pend_q;
    accept     = in_valid && in_ready;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      count_q    <= '0;
      done_q     <= 1'b0;
      fin_pend_q <= 1'b0;
`ifdef ENC_CHECK_EN
      err_q      <= 1'b0;
`endif
    end else begin
      we_q <= 1'b0;
`ifdef ENC_CHECK_EN
      err_q <= 1'b0;
`endif
      case (state_q)
        StIdle: begin
          addr_q     <= '0;
          count_q    <= '0;
          done_q     <= 1'b0;
          fin_pend_q <= 1'b0;
          if (start) begin
            state_q <= StLoad;
          end
        end

        StLoad: begin
          // Address and count advance on the edge that ends the write cycle;
          // the address saturates at the top word instead of wrapping.
          if (we_q) begin
            count_q <= count_q + (AW+1)'(1);
            if (!last_write) begin
              addr_q <= addr_q + AW'(1);
            end
          end
          if (accept) begin
            wdata_q <= word;
            we_q    <= word_ok;
`ifdef ENC_CHECK_EN
            err_q   <= !word_ok;
`endif
          end
          if (last_write || ((finish || fin_pend_q) && !accept)) begin
            state_q    <= StDone;
            done_q     <= 1'b1;
            fin_pend_q <= 1'b0;
          end else if (finish) begin
            fin_pend_q <= 1'b1;
          end
        end

        StDone: begin
          if (start) begin
            state_q <= StLoad;
            addr_q  <= '0;
            count_q <= '0;
            done_q  <= 1'b0;
          end
        end

        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign count      = count_q;
  assign done       = done_q;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Self-checking bench for instr_encoder_loader: directed scenarios plus random
// sessions checked against a session-level reference model.
module tb_instr_encoder_loader;

  localparam int AW    = 2;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          finish = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [1:0]    in_kind = '0;
  logic [4:0]    in_rs = '0;
  logic [4:0]    in_rt = '0;
  logic [4:0]    in_rd = '0;
  logic [5:0]    in_funct = '0;
  logic [15:0]   in_imm = '0;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic [AW:0]   count;
  logic          done;
  logic          err;

  int n_pass = 0;
  int n_total = 0;

  instr_encoder_loader #(.AW(AW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .finish     (finish),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_kind    (in_kind),
    .in_rs      (in_rs),
    .in_rt      (in_rt),
    .in_rd      (in_rd),
    .in_funct   (in_funct),
    .in_imm     (in_imm),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .count      (count),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  // Reference encoding from the MIPS field layout.
  function automatic logic [31:0] ref_word(input int kind, input int rs, input int rt,
                                           input int rd, input int funct, input int imm);
    logic [31:0] op;
    case (kind)
      1: op = 32'd35;
      2: op = 32'd43;
      3: op = 32'd4;
      default: op = 32'd0;
    endcase
    if (kind == 0) return (32'(rs) << 21) | (32'(rt) << 16) | (32'(rd) << 11) | 32'(funct);
    return (op << 26) | (32'(rs) << 21) | (32'(rt) << 16) | 32'(imm);
  endfunction

  function automatic bit ref_legal(input int kind, input int funct);
`ifdef ENC_CHECK_EN
    return (kind != 0) || (funct inside {32, 34, 36, 37, 42});
`else
    return 1'b1;
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int kind, input int rs, input int rt, input int rd,
                       input int funct, input int imm);
    in_valid = 1'b1;
    in_kind  = 2'(kind);
    in_rs    = 5'(rs);
    in_rt    = 5'(rt);
    in_rd    = 5'(rd);
    in_funct = 6'(funct);
    in_imm   = 16'(imm);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic end_session();
    in_valid = 1'b0;
    finish = 1'b1;
    step();
    finish = 1'b0;
    step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    n_total++; if (imem_we !== 1'b0) $display("FAIL rst_we: got %b want 0", imem_we); else n_pass++;
    n_total++; if (imem_addr !== '0) $display("FAIL rst_addr: got %h want 0", imem_addr); else n_pass++;
    n_total++; if (imem_wdata !== 32'h0) $display("FAIL rst_wdata: got %h want 0", imem_wdata); else n_pass++;
    n_total++; if (count !== '0) $display("FAIL rst_count: got %0d want 0", count); else n_pass++;
    n_total++; if (done !== 1'b0) $display("FAIL rst_done: got %b want 0", done); else n_pass++;
    n_total++; if (err !== 1'b0) $display("FAIL rst_err: got %b want 0", err); else n_pass++;
    n_total++; if (in_ready !== 1'b0) $display("FAIL rst_ready: got %b want 0", in_ready); else n_pass++;
    rst_n = 1'b1;
    step();
    n_total++; if (in_ready !== 1'b0) $display("FAIL idle_ready: got %b want 0", in_ready); else n_pass++;
  endtask

  task automatic test_lw();
    pulse_start();
    n_total++; if (in_ready !== 1'b1) $display("FAIL lw_ready: got %b want 1", in_ready); else n_pass++;
    drive(1, 0, 8, 0, 0, 16'h0004);
    step();
    in_valid = 1'b0;
    n_total++; if (imem_we !== 1'b1) $display("FAIL lw_we: got %b want 1", imem_we); else n_pass++;
    n_total++; if (imem_addr !== 2'd0) $display("FAIL lw_addr: got %h want 0", imem_addr); else n_pass++;
    n_total++; if (imem_wdata !== 32'h8C080004) $display("FAIL lw_data: got %h want 8c080004", imem_wdata); else n_pass++;
    step();
    n_total++; if (count !== 3'd1) $display("FAIL lw_count: got %0d want 1", count); else n_pass++;
    n_total++; if (imem_we !== 1'b0) $display("FAIL lw_we_drop: got %b want 0", imem_we); else n_pass++;
    end_session();
  endtask

  task automatic test_back_to_back();
    pulse_start();
    drive(0, 8, 9, 10, 6'h20, 0);
    step();
    drive(3, 8, 9, 0, 0, 16'hFFFF);
    n_total++; if (imem_we !== 1'b1 || imem_addr !== 2'd0) $display("FAIL b2b_w0: got we=%b addr=%h want 1/0", imem_we, imem_addr); else n_pass++;
    n_total++; if (imem_wdata !== 32'h01095020) $display("FAIL b2b_d0: got %h want 01095020", imem_wdata); else n_pass++;
    step();
    in_valid = 1'b0;
    n_total++; if (imem_we !== 1'b1 || imem_addr !== 2'd1) $display("FAIL b2b_w1: got we=%b addr=%h want 1/1", imem_we, imem_addr); else n_pass++;
    n_total++; if (imem_wdata !== 32'h1109FFFF) $display("FAIL b2b_d1: got %h want 1109ffff", imem_wdata); else n_pass++;
    step();
    n_total++; if (count !== 3'd2) $display("FAIL b2b_count: got %0d want 2", count); else n_pass++;
    end_session();
  endtask

  task automatic test_fill();
    pulse_start();
    for (int i = 0; i < DEPTH; i++) begin
      drive(1, i, i + 1, 0, 0, i * 4);
      n_total++; if (in_ready !== 1'b1) $display("FAIL fill_ready%0d: got %b want 1", i, in_ready); else n_pass++;
      step();
    end
    // fifth word stays valid and must never be taken
    n_total++; if (in_ready !== 1'b0) $display("FAIL fill_full_ready: got %b want 0", in_ready); else n_pass++;
    n_total++; if (imem_addr !== 2'(DEPTH - 1)) $display("FAIL fill_last_addr: got %h want %h", imem_addr, 2'(DEPTH - 1)); else n_pass++;
    step();
    n_total++; if (done !== 1'b1) $display("FAIL fill_done: got %b want 1", done); else n_pass++;
    n_total++; if (count !== 3'(DEPTH)) $display("FAIL fill_count: got %0d want %0d", count, DEPTH); else n_pass++;
    n_total++; if (imem_we !== 1'b0 || in_ready !== 1'b0) $display("FAIL fill_after: got we=%b ready=%b want 0/0", imem_we, in_ready); else n_pass++;
    step();
    n_total++; if (imem_we !== 1'b0) $display("FAIL fill_no_fifth: got %b want 0", imem_we); else n_pass++;
    in_valid = 1'b0;
  endtask

  task automatic test_finish_sw();
    pulse_start();
    drive(2, 29, 8, 0, 0, 8);
    finish = 1'b1;
    step();
    finish = 1'b0;
    in_valid = 1'b0;
    n_total++; if (imem_we !== 1'b1 || imem_wdata !== 32'hAFA80008) $display("FAIL fin_write: got we=%b data=%h want 1/afa80008", imem_we, imem_wdata); else n_pass++;
    n_total++; if (done !== 1'b0) $display("FAIL fin_early_done: got %b want 0", done); else n_pass++;
    step();
    n_total++; if (done !== 1'b1 || count !== 3'd1) $display("FAIL fin_done: got done=%b count=%0d want 1/1", done, count); else n_pass++;
    pulse_start();
    n_total++; if (imem_addr !== 2'd0 || count !== 3'd0 || done !== 1'b0) $display("FAIL restart: got addr=%h count=%0d done=%b want 0/0/0", imem_addr, count, done); else n_pass++;
    drive(1, 1, 2, 0, 0, 16'h0010);
    step();
    in_valid = 1'b0;
    n_total++; if (imem_we !== 1'b1 || imem_addr !== 2'd0) $display("FAIL restart_write: got we=%b addr=%h want 1/0", imem_we, imem_addr); else n_pass++;
    end_session();
  endtask

  task automatic test_reset_mid();
    pulse_start();
    drive(1, 3, 4, 0, 0, 16'h1234);
    step();
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    n_total++; if (imem_we !== 1'b0) $display("FAIL rstmid_we: got %b want 0", imem_we); else n_pass++;
    n_total++; if (imem_wdata !== 32'h0 || imem_addr !== '0 || count !== '0) $display("FAIL rstmid_regs: got data=%h addr=%h count=%0d want 0", imem_wdata, imem_addr, count); else n_pass++;
    n_total++; if (done !== 1'b0 || err !== 1'b0 || in_ready !== 1'b0) $display("FAIL rstmid_flags: got done=%b err=%b ready=%b want 0", done, err, in_ready); else n_pass++;
    step();
    rst_n = 1'b1;
    step();
    n_total++; if (imem_we !== 1'b0 || in_ready !== 1'b0) $display("FAIL rstmid_idle: got we=%b ready=%b want 0/0", imem_we, in_ready); else n_pass++;
  endtask

  task automatic test_funct_check();
    pulse_start();
    drive(0, 8, 9, 10, 6'h3F, 0);
    step();
    in_valid = 1'b0;
`ifdef ENC_CHECK_EN
    n_total++; if (err !== 1'b1 || imem_we !== 1'b0) $display("FAIL chk_reject: got err=%b we=%b want 1/0", err, imem_we); else n_pass++;
    step();
    n_total++; if (err !== 1'b0 || imem_addr !== 2'd0 || count !== 3'd0) $display("FAIL chk_after: got err=%b addr=%h count=%0d want 0/0/0", err, imem_addr, count); else n_pass++;
`else
    n_total++; if (imem_we !== 1'b1 || imem_wdata !== 32'h0109503F) $display("FAIL nochk_write: got we=%b data=%h want 1/0109503f", imem_we, imem_wdata); else n_pass++;
    n_total++; if (err !== 1'b0) $display("FAIL nochk_err: got %b want 0", err); else n_pass++;
`endif
    end_session();
  endtask

  task automatic test_random_session(input int sid);
    int  n_legal;
    int  kind, rs, rt, rd, funct, imm;
    bit  fin, acc, legal, ended, exp_ready;
    logic [31:0] exp_word;
    pulse_start();
    n_legal = 0;
    fin = 1'b0;
    ended = 1'b0;
    for (int cyc = 0; cyc < 40 && !ended; cyc++) begin
      kind  = int'($urandom_range(0, 3));
      rs    = int'($urandom_range(0, 31));
      rt    = int'($urandom_range(0, 31));
      rd    = int'($urandom_range(0, 31));
      funct = ($urandom_range(0, 1) == 0) ? 32 + 2 * int'($urandom_range(0, 5))
                                          : int'($urandom_range(0, 63));
      imm   = int'($urandom_range(0, 65535));
      drive(kind, rs, rt, rd, funct, imm);
      in_valid = ($urandom_range(0, 3) != 0);
      finish = !fin && ($urandom_range(0, 7) == 0 || cyc == 30);
      exp_ready = !fin && (n_legal < DEPTH);
      n_total++; if (in_ready !== exp_ready) $display("FAIL rnd%0d_ready c%0d: got %b want %b", sid, cyc, in_ready, exp_ready); else n_pass++;
      acc = in_valid && exp_ready;
      legal = ref_legal(kind, funct);
      exp_word = ref_word(kind, rs, rt, rd, funct, imm);
      if (finish) fin = 1'b1;
      step();
      finish = 1'b0;
      n_total++; if (imem_we !== (acc && legal)) $display("FAIL rnd%0d_we c%0d: got %b want %b", sid, cyc, imem_we, acc && legal); else n_pass++;
      if (acc && legal) begin
        n_total++; if (imem_addr !== AW'(n_legal) || imem_wdata !== exp_word) $display("FAIL rnd%0d_write c%0d: got addr=%h data=%h want %h/%h", sid, cyc, imem_addr, imem_wdata, AW'(n_legal), exp_word); else n_pass++;
      end
      n_total++; if (err !== (acc && !legal)) $display("FAIL rnd%0d_err c%0d: got %b want %b", sid, cyc, err, acc && !legal); else n_pass++;
      n_total++; if (count !== (AW+1)'(n_legal)) $display("FAIL rnd%0d_count c%0d: got %0d want %0d", sid, cyc, count, n_legal); else n_pass++;
      if (acc && legal) n_legal++;
      if (fin || n_legal == DEPTH) begin
        if (acc) begin
          in_valid = ($urandom_range(0, 1) != 0);
          n_total++; if (in_ready !== 1'b0) $display("FAIL rnd%0d_tail_ready: got %b want 0", sid, in_ready); else n_pass++;
          step();
          n_total++; if (imem_we !== 1'b0) $display("FAIL rnd%0d_tail_we: got %b want 0", sid, imem_we); else n_pass++;
        end
        n_total++; if (done !== 1'b1 || in_ready !== 1'b0) $display("FAIL rnd%0d_end: got done=%b ready=%b want 1/0", sid, done, in_ready); else n_pass++;
        n_total++; if (count !== (AW+1)'(n_legal)) $display("FAIL rnd%0d_end_count: got %0d want %0d", sid, count, n_legal); else n_pass++;
        ended = 1'b1;
      end else begin
        n_total++; if (done !== 1'b0) $display("FAIL rnd%0d_done c%0d: got %b want 0", sid, cyc, done); else n_pass++;
      end
    end
    in_valid = 1'b0;
    n_total++; if (!ended) $display("FAIL rnd%0d_timeout: got running want done", sid); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_lw();
    test_back_to_back();
    test_fill();
    test_finish_sw();
    test_reset_mid();
    test_funct_check();
    for (int s = 0; s < 20; s++) begin
      test_random_session(s);
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/instr_encoder_loader.md
# instr_encoder_loader

Streams field-level instruction descriptions (kind, registers, funct, immediate) into MIPS machine words and writes them sequentially into instruction memory. It sits between a bench or boot host and the instruction memory of the single-cycle processor. It produces exactly the opcode/field encodings that the processor's control decoding consumes: R-type, LW, SW and BEQ. It uses a valid/ready input handshake, a registered write port, an address counter and a small load FSM.

## Interface
- `AW`, 6: instruction memory address width in words; capacity `DEPTH = 2**AW`.
- `clk` input 1: single clock; all state updates on its rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `start` input 1: one-cycle pulse; begins a load session at word address 0.
- `finish` input 1: one-cycle pulse; ends the session early.
- `in_valid` input 1: instruction fields valid.
- `in_ready` output 1: encoder accepts fields this cycle.
- `in_kind` input 2: 0 = R-type, 1 = LW, 2 = SW, 3 = BEQ.
- `in_rs`, `in_rt`, `in_rd` inputs 5 each: register fields.
- `in_funct` input 6: R-type function code.
- `in_imm` input 16: immediate or branch offset.
- `imem_we` output 1: instruction memory write enable.
- `imem_addr` output AW: word address.
- `imem_wdata` output 32: encoded instruction.
- `count` output AW+1: words written in the current session.
- `done` output 1: session finished.
- `err` output 1: one-cycle pulse when a word is rejected (see Configuration).

## Operation
- FSM states are IDLE, LOAD and DONE. Reset state is IDLE.
- **IDLE:**
  - `start` → LOAD.
  - `addr` is set to 0 and `count` is set to 0.
- **LOAD:**
  - `in_ready = 1` except on the cycle an internal write completes the last slot.
  - Handshake: a word is accepted when `in_valid && in_ready`.
  - The fields are encoded and registered.
- **Encodings:**
  - R-type: {000000, rs, rt, rd, 00000, funct}.
  - LW: {100011, rs, rt, imm}.
  - SW: {101011, rs, rt, imm}.
  - BEQ: {000100, rs, rt, imm}.
  - `in_rd` is ignored for I-types. `in_funct` is ignored for non-R kinds.
- **Address and count:**
  - After each write, the address increments by 1 and `count` increments by 1.
  - The address never wraps. When the write to address DEPTH-1 occurs, the FSM goes to DONE in the same edge.
- **finish:**
  - `finish` in LOAD → DONE after any accepted word is written.
  - If `finish` and an acceptance coincide, the word is written, then DONE.
- **DONE:**
  - `done = 1` and `in_ready = 0`.
  - `start` → LOAD with address and count cleared to 0.
- `start` is ignored in LOAD. `finish` is ignored in IDLE and DONE.
- Reset mid-session: any pending write is dropped, the FSM returns to IDLE, and all outputs are cleared.

## Timing
- Reset values: `in_ready = 0`, `imem_we = 0`, `imem_addr = 0`, `imem_wdata = 0`, `count = 0`, `done = 0`, `err = 0`.
- Latency: a word accepted in cycle N has `imem_we = 1` in cycle N+1, with its address and data stable for that cycle.
- Throughput: one word per cycle. Back-to-back acceptances produce consecutive addresses.
- `in_ready` is combinational from state and the full condition only. It never depends on `in_valid`.
- `count` and `imem_addr` update on the edge ending the write cycle.
- `done` rises on the edge after the last write or after `finish`.

## Configuration
- Macro: `ENC_CHECK_EN`.
- **With the macro defined:**
  - An R-type word is accepted only if its funct is in {100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt}.
  - An illegal funct is still handshaken (consumed), but no write occurs, the address does not advance, and `err` pulses in cycle N+1.
- **Without the macro:** all kinds and functs are encoded and written, and `err` is tied 0.

## Structure
- Shared package `mips_pkg`:
  - Opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ).
  - Funct constants.
  - The 2-bit instruction kind typedef.
  - The FSM state typedef.
- Sub-module `instr_pack`: combinational field-to-word packer. It is reusable by other benches.

## Test plan
- Reset, then `start`, then LW with rs=0, rt=8, imm=0x0004 → `imem_we` at addr 0, data 0x8C080004, then `count = 1`.
- Back-to-back R-type add (rs=8, rt=9, rd=10, funct=0x20) followed by BEQ (rs=8, rt=9, imm=0xFFFF) → writes 0x01095020 at addr 0 and 0x1109FFFF at addr 1 in consecutive cycles.
- Fill with AW=2: accept 4 words → `in_ready` drops after the 4th acceptance, `done = 1`, and a 5th `in_valid` is never accepted.
- `finish` coinciding with an SW acceptance (rs=29, rt=8, imm=8) → 0xAFA80008 is written, then `done = 1`, then `start` restarts at addr 0.
- Assert `rst_n` low in the cycle after an acceptance → no write appears, and all outputs are 0.
- With `ENC_CHECK_EN`: R-type funct=0x3F → `err` pulse, no write, address unchanged. Without the macro: the same stimulus writes 0x0109503F.
